// File: rtl/if_pkg.sv
// Shared types and constants for the instruction-fetch stage.
package if_pkg;

  // Fetch FSM: normal issue, or waiting out a request made stale by a redirect
  typedef enum logic [0:0] {
    FETCH = 1'b0,
    DRAIN = 1'b1
  } if_state_t;

  localparam logic [31:0] PC_STEP          = 32'd4;
  localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

  // One fetched word together with the address that follows it
  typedef struct packed {
    logic [31:0] pc_next;
    logic [31:0] instruction;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_buffer.sv
// Two-entry in-order fetch buffer: an output slot feeding id_stage plus a
// skid slot that catches the word returning while the output slot is held.
// Handshake: push writes one entry this cycle; pop consumes the output slot
// this cycle; clear empties both slots and wins over push and pop. The owner
// must never push while the skid slot is full and not being drained.
module fetch_buffer
  import if_pkg::*;
(
  input  logic         clk,
  input  logic         reset,
  input  logic         push,
  input  fetch_entry_t push_entry,
  input  logic         pop,
  input  logic         clear,
  output logic         out_valid,
  output logic         skid_valid,
  output fetch_entry_t out_entry
);

  fetch_entry_t skid_entry;

  // Slot update: output slot refills from skid first, then from the new word
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      out_valid  <= 1'b0;
      skid_valid <= 1'b0;
      out_entry  <= '0;
      skid_entry <= '0;
    end else if (clear) begin
      out_valid  <= 1'b0;
      skid_valid <= 1'b0;
    end else if (pop || !out_valid) begin
      if (skid_valid) begin
        out_entry  <= skid_entry;
        out_valid  <= 1'b1;
        skid_valid <= push;
        if (push) skid_entry <= push_entry;
      end else begin
        out_valid <= push;
        if (push) out_entry <= push_entry;
      end
    end else if (push) begin
      skid_entry <= push_entry;
      skid_valid <= 1'b1;
    end
  end

endmodule

// File: rtl/if_stage.sv
// Instruction-fetch stage: owns the PC, issues word reads over imem_req /
// imem_ack and feeds id_stage through a two-entry fetch buffer.
// Memory handshake: imem_req with imem_addr is held stable until imem_ack;
// a word is taken only in a cycle where imem_req and imem_ack are both high.
// Optional feature macro: IF_MISALIGN_EXC_EN (misaligned redirect raises
// exc_adel and halts fetching; without it redirect_pc[1:0] is ignored).
module if_stage
  import if_pkg::*;
#(
  parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic [31:0] instruction,
  output logic [31:0] pc_next,
  output logic        id_we,
  output logic        id_flush,
`ifdef IF_MISALIGN_EXC_EN
  output logic        exc_adel,
`endif
  output if_state_t   state_dbg
);

  if_state_t    state;
  logic [31:0]  pc;
  logic [31:0]  target;
  logic [31:0]  redir_pc_eff;
  logic         misalign;
  logic         fetch_halt;
  logic         accept;
  logic         pop;
  logic         push;
  logic         out_valid;
  logic         skid_valid;
  fetch_entry_t push_entry;
  fetch_entry_t out_entry;

`ifdef IF_MISALIGN_EXC_EN
  assign redir_pc_eff = redirect_pc;
  assign misalign     = redirect && (redirect_pc[1:0] != 2'b00);
  assign fetch_halt   = exc_adel;

  // Sticky address-error flag, cleared only by reset
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) exc_adel <= 1'b0;
    else if (misalign) exc_adel <= 1'b1;
  end
`else
  logic unused_rpc_bits;
  assign unused_rpc_bits = ^redirect_pc[1:0];
  assign redir_pc_eff    = {redirect_pc[31:2], 2'b00};
  assign misalign        = 1'b0;
  assign fetch_halt      = 1'b0;
`endif

  // A stale request in DRAIN must stay up; otherwise stop when skid is full
  assign imem_req  = !fetch_halt && ((state == DRAIN) || !skid_valid);
  assign imem_addr = pc;
  assign accept    = imem_req && imem_ack;
  assign pop       = out_valid && !stall;
  assign push      = (state == FETCH) && accept && !redirect;

  assign push_entry.pc_next     = pc + PC_STEP;
  assign push_entry.instruction = imem_rdata;

  assign instruction = out_entry.instruction;
  assign pc_next     = out_entry.pc_next;
  assign id_we       = out_valid && !stall && !redirect && !fetch_halt;
  assign id_flush    = fetch_halt || redirect || (!out_valid && !stall);
  assign state_dbg   = state;

  fetch_buffer u_fetch_buffer (
    .clk        (clk),
    .reset      (reset),
    .push       (push),
    .push_entry (push_entry),
    .pop        (pop),
    .clear      (redirect),
    .out_valid  (out_valid),
    .skid_valid (skid_valid),
    .out_entry  (out_entry)
  );

  // PC / redirect FSM: the PC only moves once the word for it has returned
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state  <= FETCH;
      pc     <= RESET_PC;
      target <= '0;
    end else if (misalign) begin
      pc    <= redirect_pc;
      state <= FETCH;
    end else if (state == FETCH) begin
      if (redirect) begin
        if (imem_req && !imem_ack) begin
          // keep the address on the bus until the stale word comes back
          target <= redir_pc_eff;
          state  <= DRAIN;
        end else begin
          pc <= redir_pc_eff;
        end
      end else if (accept) begin
        pc <= pc + PC_STEP;
      end
    end else begin
      if (redirect) target <= redir_pc_eff;
      if (imem_ack) begin
        pc    <= redirect ? redir_pc_eff : target;
        state <= FETCH;
      end
    end
  end

endmodule

// File: tb/tb_if_stage.sv
// Testbench for if_stage: hand-derived vector table, reset and corner
// sequences, and randomized traffic checked against a queue-based model.
module tb_if_stage;
  import if_pkg::*;

  localparam logic [31:0] RPC = 32'h0000_0100;

  // ---------------- clock / reset ----------------
  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        stall = 1'b0;
  logic        redirect = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic        imem_ack = 1'b0;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata;
  logic [31:0] instruction;
  logic [31:0] pc_next;
  logic        id_we;
  logic        id_flush;
  if_state_t   state_dbg;
`ifdef IF_MISALIGN_EXC_EN
  logic        exc_adel;
`endif

  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[15:0], a[31:16]} ^ 32'hC0DE_0000;
  endfunction

  assign imem_rdata = mem_word(imem_addr);

  if_stage #(.RESET_PC(RPC)) dut (
    .clk         (clk),
    .reset       (reset),
    .stall       (stall),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_ack    (imem_ack),
    .imem_rdata  (imem_rdata),
    .instruction (instruction),
    .pc_next     (pc_next),
    .id_we       (id_we),
    .id_flush    (id_flush),
`ifdef IF_MISALIGN_EXC_EN
    .exc_adel    (exc_adel),
`endif
    .state_dbg   (state_dbg)
  );

  // ---------------- scoreboard ----------------
  int n_total = 0;
  int n_pass  = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %08h expected %08h at %0t", nm, act, exp, $time);
  endtask

  // Reference model: addresses fetched but not yet handed to ID, in order
  logic [31:0] exp_q[$];
  logic [31:0] m_pc;
  logic        m_drain;
  logic [31:0] m_target;

  task automatic model_reset();
    exp_q.delete();
    m_pc     = RPC;
    m_drain  = 1'b0;
    m_target = '0;
  endtask

  task automatic model_tick();
    logic        e_req, e_we, e_fl;
    logic [31:0] rpe;
    e_req = m_drain || (exp_q.size() < 2);
    e_we  = (exp_q.size() != 0) && !stall && !redirect;
    e_fl  = redirect || ((exp_q.size() == 0) && !stall);
    chk("m_req",   32'(imem_req), 32'(e_req));
    chk("m_addr",  imem_addr, m_pc);
    chk("m_we",    32'(id_we), 32'(e_we));
    chk("m_flush", 32'(id_flush), 32'(e_fl));
    chk("m_state", 32'(state_dbg), 32'(m_drain));
    if (exp_q.size() != 0) begin
      chk("m_pc_next", pc_next, exp_q[0] + 32'd4);
      chk("m_instr",   instruction, mem_word(exp_q[0]));
    end
`ifdef IF_MISALIGN_EXC_EN
    rpe = redirect_pc;
`else
    rpe = redirect_pc & 32'hFFFF_FFFC;
`endif
    if (redirect) begin
      exp_q.delete();
      if (!m_drain) begin
        if (e_req && !imem_ack) begin
          m_drain  = 1'b1;
          m_target = rpe;
        end else begin
          m_pc = rpe;
        end
      end else if (imem_ack) begin
        m_pc    = rpe;
        m_drain = 1'b0;
      end else begin
        m_target = rpe;
      end
    end else if (m_drain) begin
      if (imem_ack) begin
        m_pc    = m_target;
        m_drain = 1'b0;
      end
    end else begin
      if (e_we) void'(exp_q.pop_front());
      if (e_req && imem_ack) begin
        exp_q.push_back(m_pc);
        m_pc = m_pc + 32'd4;
      end
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic drive(input logic s, input logic r, input logic [31:0] rp, input logic a);
    stall       = s;
    redirect    = r;
    redirect_pc = rp;
    imem_ack    = a;
    @(negedge clk);
  endtask

  task automatic step(input logic s, input logic r, input logic [31:0] rp, input logic a);
    drive(s, r, rp, a);
    model_tick();
    @(posedge clk);
    #1;
  endtask

  task automatic reset_checks();
    chk("rst_req",     32'(imem_req), 32'd1);
    chk("rst_addr",    imem_addr, RPC);
    chk("rst_we",      32'(id_we), 32'd0);
    chk("rst_flush",   32'(id_flush), 32'd1);
    chk("rst_instr",   instruction, 32'd0);
    chk("rst_pc_next", pc_next, 32'd0);
    chk("rst_state",   32'(state_dbg), 32'(FETCH));
`ifdef IF_MISALIGN_EXC_EN
    chk("rst_exc",     32'(exc_adel), 32'd0);
`endif
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic        s, r;
    logic [31:0] rp;
    logic        a;
    logic        req;
    logic [31:0] addr;
    logic        we, fl, dr;
    logic [31:0] pcn;
  } vec_t;

  vec_t vecs[23];
  int   we_cnt;

  initial begin
    // s r rp a | req addr we fl dr pcn
    vecs[0]  = '{0, 0, 32'h0,         1, 1, 32'h100,       0, 1, 0, 32'h0};
    vecs[1]  = '{0, 0, 32'h0,         1, 1, 32'h104,       1, 0, 0, 32'h104};
    vecs[2]  = '{0, 0, 32'h0,         1, 1, 32'h108,       1, 0, 0, 32'h108};
    vecs[3]  = '{1, 0, 32'h0,         1, 1, 32'h10C,       0, 0, 0, 32'h0};
    vecs[4]  = '{1, 0, 32'h0,         1, 0, 32'h110,       0, 0, 0, 32'h0};
    vecs[5]  = '{1, 0, 32'h0,         1, 0, 32'h110,       0, 0, 0, 32'h0};
    vecs[6]  = '{1, 0, 32'h0,         1, 0, 32'h110,       0, 0, 0, 32'h0};
    vecs[7]  = '{0, 0, 32'h0,         1, 0, 32'h110,       1, 0, 0, 32'h10C};
    vecs[8]  = '{0, 0, 32'h0,         1, 1, 32'h110,       1, 0, 0, 32'h110};
    vecs[9]  = '{0, 0, 32'h0,         0, 1, 32'h114,       1, 0, 0, 32'h114};
    vecs[10] = '{0, 0, 32'h0,         0, 1, 32'h114,       0, 1, 0, 32'h0};
    vecs[11] = '{0, 0, 32'h0,         1, 1, 32'h114,       0, 1, 0, 32'h0};
    vecs[12] = '{0, 0, 32'h0,         0, 1, 32'h118,       1, 0, 0, 32'h118};
    vecs[13] = '{0, 1, 32'h2000,      0, 1, 32'h118,       0, 1, 0, 32'h0};
    vecs[14] = '{0, 0, 32'h0,         0, 1, 32'h118,       0, 1, 1, 32'h0};
    vecs[15] = '{0, 0, 32'h0,         1, 1, 32'h118,       0, 1, 1, 32'h0};
    vecs[16] = '{0, 0, 32'h0,         1, 1, 32'h2000,      0, 1, 0, 32'h0};
    vecs[17] = '{1, 1, 32'h3000,      1, 1, 32'h2004,      0, 1, 0, 32'h0};
    vecs[18] = '{0, 0, 32'h0,         1, 1, 32'h3000,      0, 1, 0, 32'h0};
    vecs[19] = '{0, 1, 32'hFFFF_FFFC, 1, 1, 32'h3004,      0, 1, 0, 32'h0};
    vecs[20] = '{0, 0, 32'h0,         1, 1, 32'hFFFF_FFFC, 0, 1, 0, 32'h0};
    vecs[21] = '{0, 0, 32'h0,         1, 1, 32'h0,         1, 0, 0, 32'h0};
    vecs[22] = '{0, 0, 32'h0,         0, 1, 32'h4,         1, 0, 0, 32'h4};

    // reset state, then release between edges
    @(negedge clk);
    reset_checks();
    @(posedge clk);
    #1;
    reset = 1'b1;
    model_reset();

    for (int i = 0; i < 23; i++) begin
      drive(vecs[i].s, vecs[i].r, vecs[i].rp, vecs[i].a);
      chk($sformatf("v%0d_req", i),   32'(imem_req), 32'(vecs[i].req));
      chk($sformatf("v%0d_addr", i),  imem_addr, vecs[i].addr);
      chk($sformatf("v%0d_we", i),    32'(id_we), 32'(vecs[i].we));
      chk($sformatf("v%0d_flush", i), 32'(id_flush), 32'(vecs[i].fl));
      chk($sformatf("v%0d_state", i), 32'(state_dbg), 32'(vecs[i].dr));
      if (vecs[i].we) begin
        chk($sformatf("v%0d_pc_next", i), pc_next, vecs[i].pcn);
        chk($sformatf("v%0d_instr", i), instruction, mem_word(vecs[i].pcn - 32'd4));
      end
      model_tick();
      @(posedge clk);
      #1;
    end

    // reset while a request is outstanding abandons it
    drive(1'b0, 1'b0, 32'h0, 1'b0);
    reset = 1'b0;
    #1;
    reset_checks();
    @(posedge clk);
    #1;
    reset = 1'b1;
    model_reset();

    // ack every third cycle: one id_we per three cycles
    we_cnt = 0;
    for (int i = 0; i < 9; i++) begin
      drive(1'b0, 1'b0, 32'h0, (i % 3) == 0);
      if (id_we) we_cnt++;
      model_tick();
      @(posedge clk);
      #1;
    end
    chk("third_we_count", 32'(we_cnt), 32'd3);

    // randomized traffic against the model
    for (int i = 0; i < 1500; i++) begin
      logic        s, r, a;
      logic [31:0] rp;
      s  = ($urandom_range(0, 3) == 0);
      r  = ($urandom_range(0, 19) == 0);
      a  = ($urandom_range(0, 9) < 6);
      rp = $urandom();
      if ($urandom_range(0, 3) == 0) rp = 32'hFFFF_FFE0 | (rp & 32'h1F);
`ifdef IF_MISALIGN_EXC_EN
      rp = rp & 32'hFFFF_FFFC;
`endif
      step(s, r, rp, a);
    end

    // misaligned redirect target
    step(1'b0, 1'b1, 32'h0000_2002, 1'b1);
`ifdef IF_MISALIGN_EXC_EN
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 1'b0, 32'h0, 1'b1);
      chk("exc_adel",  32'(exc_adel), 32'd1);
      chk("exc_req",   32'(imem_req), 32'd0);
      chk("exc_we",    32'(id_we), 32'd0);
      chk("exc_flush", 32'(id_flush), 32'd1);
      @(posedge clk);
      #1;
    end
`else
    drive(1'b0, 1'b0, 32'h0, 1'b0);
    chk("masked_redirect_addr", imem_addr, 32'h0000_2000);
    chk("masked_redirect_req",  32'(imem_req), 32'd1);
    @(posedge clk);
    #1;
`endif

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
